// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial FSM state encoding and
// the sizing helper for bit counters that walk a WIDTH-bit operand.
package arith_pkg;

   // Control states shared by the bit-serial arithmetic blocks.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } serial_state_t;

   // Bits needed to index 0..w-1. Never returns less than one bit.
   function automatic int cnt_width(input int w);
      if (w <= 2) begin
         return 1;
      end
      return $clog2(w);
   endfunction

endpackage : arith_pkg

// File: rtl/serial_full_adder.sv
// One-bit full-adder cell. It is reused once per clock by the serial
// subtractor, which feeds it the inverted subtrahend bit.
module serial_full_adder (
   input  logic a,
   input  logic b,
   input  logic carry,
   output logic sum,
   output logic carry_d
);

   // Sum bit and majority carry, built from plain gates only.
   always_comb begin
      sum     = a ^ b ^ carry;
      carry_d = (a & b) | (a & carry) | (b & carry);
   end

endmodule : serial_full_adder

// File: rtl/serial_signed_sub_with_overflow.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one
// bit per clock. a - b is computed as a + ~b + 1, so the carry flop
// starts at 1 and the adder cell sees the inverted b bit. Valid/ready
// handshakes on both sides let the block sit between pipeline stages.
module serial_signed_sub_with_overflow
   import arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [WIDTH-1:0] diff,
   output logic             overflow
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   serial_state_t    r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_diff;
   logic             r_overflow;
   logic             r_up_ready;
   logic             r_down_valid;

   logic [WIDTH-1:0] w_b_inv;
   logic             w_a_bit;
   logic             w_b_bit;
   logic             w_sum;
   logic             w_carry_d;

   // Subtrahend is added in inverted form; invert each latched bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_b_inv
         assign w_b_inv[gi] = ~r_b[gi];
      end
   endgenerate

   assign w_a_bit = r_a[r_cnt];
   assign w_b_bit = w_b_inv[r_cnt];

   serial_full_adder u_fa (
      .a       (w_a_bit),
      .b       (w_b_bit),
      .carry   (r_carry),
      .sum     (w_sum),
      .carry_d (w_carry_d)
   );

   // Control FSM plus datapath registers: accept, shift WIDTH bits, hold result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_cnt        <= '0;
         r_carry      <= 1'b1;
         r_diff       <= '0;
         r_overflow   <= 1'b0;
         r_up_ready   <= 1'b1;
         r_down_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (up_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_carry    <= 1'b1;
                  r_cnt      <= '0;
                  r_up_ready <= 1'b0;
                  r_state    <= BUSY;
               end
            end
            BUSY: begin
               // New sum bit enters at the MSB; after WIDTH shifts the
               // result is right-aligned with bit 0 at the LSB.
               r_diff  <= {w_sum, r_diff[WIDTH-1:1]};
               r_carry <= w_carry_d;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  // Carry into the MSB differs from carry out of it.
                  r_overflow   <= r_carry ^ w_carry_d;
                  r_cnt        <= '0;
                  r_down_valid <= 1'b1;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               // Result holds until taken; new operands wait one more cycle.
               if (down_ready) begin
                  r_down_valid <= 1'b0;
                  r_up_ready   <= 1'b1;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_down_valid <= 1'b0;
               r_up_ready   <= 1'b1;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign up_ready   = r_up_ready;
   assign down_valid = r_down_valid;
   assign diff       = r_diff;
   assign overflow   = r_overflow;

endmodule : serial_signed_sub_with_overflow

// File: tb/tb_serial_signed_sub_with_overflow.sv
// Directed and exhaustive checks for the WIDTH=4 bit-serial subtractor.
module tb_serial_signed_sub_with_overflow;

   logic       clk = 1'b0;
   logic       rst;
   logic       up_valid;
   logic       up_ready;
   logic [3:0] a_s;
   logic [3:0] b_s;
   logic       down_valid;
   logic       down_ready;
   logic [3:0] diff;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] diff;
      logic       ov;
   } vec_t;

   vec_t vecs[9];

   serial_signed_sub_with_overflow #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .a          (a_s),
      .b          (b_s),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .diff       (diff),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Step edges until down_valid is seen; returns edges waited (bounded).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!down_valid && n < 20);
   endtask

   // One full transaction with down_ready high: accept, latency, result, handshake.
   task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic [3:0] ed, input logic eo, input string tag);
      int n;
      check({tag, " ready_idle"}, 32'(up_ready), 32'd1);
      a_s = ta; b_s = tb_v; up_valid = 1'b1;
      @(posedge clk); #1;
      up_valid = 1'b0;
      wait_done(n);
      check({tag, " latency"}, 32'(n), 32'd4);
      check({tag, " diff"}, 32'(diff), 32'(ed));
      check({tag, " overflow"}, 32'(overflow), 32'(eo));
      $display("op %s: a=%b b=%b diff=%b ov=%b lat=%0d", tag, ta, tb_v, diff, overflow, n);
      @(posedge clk); #1;
      check({tag, " dv_drop"}, 32'(down_valid), 32'd0);
      check({tag, " ready_back"}, 32'(up_ready), 32'd1);
   endtask

   initial begin
      int n;
      int seen;
      int full;
      logic [3:0] hold_d;
      logic       hold_o;
      logic [3:0] ea;
      logic [3:0] eb;

      vecs[0] = '{a: 4'd3,    b: 4'd5,    diff: 4'b1110, ov: 1'b0}; //  3 - 5
      vecs[1] = '{a: 4'b1000, b: 4'd1,    diff: 4'b0111, ov: 1'b1}; // -8 - 1
      vecs[2] = '{a: 4'd7,    b: 4'b1111, diff: 4'b1000, ov: 1'b1}; //  7 - (-1)
      vecs[3] = '{a: 4'd0,    b: 4'b1000, diff: 4'b1000, ov: 1'b1}; //  0 - (-8)
      vecs[4] = '{a: 4'b1111, b: 4'b1111, diff: 4'b0000, ov: 1'b0}; // -1 - (-1)
      vecs[5] = '{a: 4'd5,    b: 4'd3,    diff: 4'b0010, ov: 1'b0}; //  5 - 3
      vecs[6] = '{a: 4'b1000, b: 4'b1000, diff: 4'b0000, ov: 1'b0}; // -8 - (-8)
      vecs[7] = '{a: 4'd7,    b: 4'b1000, diff: 4'b1111, ov: 1'b1}; //  7 - (-8)
      vecs[8] = '{a: 4'b1000, b: 4'd7,    diff: 4'b0001, ov: 1'b1}; // -8 - 7

      rst = 1'b1; up_valid = 1'b0; a_s = '0; b_s = '0; down_ready = 1'b1;
      #3;
      check("rst up_ready", 32'(up_ready), 32'd1);
      check("rst down_valid", 32'(down_valid), 32'd0);
      check("rst diff", 32'(diff), 32'd0);
      check("rst overflow", 32'(overflow), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].ov, $sformatf("vec%0d", i));
      end

      // Stall in DONE with new operands offered: everything must hold.
      down_ready = 1'b0;
      a_s = 4'd3; b_s = 4'd5; up_valid = 1'b1;
      @(posedge clk); #1;
      a_s = 4'd6; b_s = 4'd2;
      wait_done(n);
      check("stall latency", 32'(n), 32'd4);
      hold_d = diff; hold_o = overflow;
      check("stall diff", 32'(diff), 32'b1110);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("stall dv", 32'(down_valid), 32'd1);
         check("stall up_ready", 32'(up_ready), 32'd0);
         check("stall diff hold", 32'(diff), 32'b1110);
         check("stall ov hold", 32'(overflow), 32'd0);
      end
      up_valid = 1'b0;
      down_ready = 1'b1;
      @(posedge clk); #1;
      check("stall release dv", 32'(down_valid), 32'd0);
      check("stall release up_ready", 32'(up_ready), 32'd1);
      check("stall release diff", 32'(diff), 32'(hold_d));
      check("stall release ov", 32'(overflow), 32'(hold_o));
      $display("op stall: a=0011 b=0101 diff=%b ov=%b", diff, overflow);

      // Back-to-back with up_valid held high across two operand pairs.
      a_s = 4'd3; b_s = 4'd5; up_valid = 1'b1;
      @(posedge clk); #1;
      a_s = 4'b1000; b_s = 4'd1;
      wait_done(n);
      check("b2b first latency", 32'(n), 32'd4);
      check("b2b first diff", 32'(diff), 32'b1110);
      check("b2b first ov", 32'(overflow), 32'd0);
      $display("op b2b1: diff=%b ov=%b", diff, overflow);
      wait_done(n);
      check("b2b second latency", 32'(n), 32'd6);
      up_valid = 1'b0;
      check("b2b second diff", 32'(diff), 32'b0111);
      check("b2b second ov", 32'(overflow), 32'd1);
      $display("op b2b2: diff=%b ov=%b", diff, overflow);
      @(posedge clk); #1;
      check("b2b idle", 32'(up_ready), 32'd1);

      // Reset in BUSY at cnt=2, after a result with nonzero diff/overflow.
      do_op(4'd7, 4'b1111, 4'b1000, 1'b1, "pre_rst");
      a_s = 4'd3; b_s = 4'd5; up_valid = 1'b1;
      @(posedge clk); #1;
      up_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst up_ready", 32'(up_ready), 32'd1);
      check("midrst down_valid", 32'(down_valid), 32'd0);
      check("midrst diff", 32'(diff), 32'd0);
      check("midrst overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (down_valid) seen++;
      end
      check("midrst no dv pulse", 32'(seen), 32'd0);
      check("midrst still idle", 32'(up_ready), 32'd1);
      $display("op midrst: aborted, diff=%b ov=%b", diff, overflow);

      // Exhaustive sweep against an integer reference.
      for (int i = 0; i < 256; i++) begin
         ea = i[7:4];
         eb = i[3:0];
         full = int'($signed(ea)) - int'($signed(eb));
         do_op(ea, eb, full[3:0], (full > 7 || full < -8), $sformatf("sweep%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_signed_sub_with_overflow
